ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Configuration-chain loader that sits directly upstream of a switch-block/tile configuration chain (e.g. the 18 x 2-bit mux memories of sb_2__0_, CHAIN_LEN = 36).
- Accepts bitstream words over a valid/ready handshake and serializes them MSB-first onto ccff_head.
- Produces a clock-enable for the chain's gated programming clock, so the chain advances only on real bits.
- Packs the bits emerging from ccff_tail (previous configuration) into readback words.

Parameters:
- WORD_W, 8, bitstream / readback word width.
- CHAIN_LEN, 36, total configuration bits in the downstream chain (>= 1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the shifted-bit counter.

Ports:
- prog_clk  in  1  programming clock; all flops on rising edge.
- pReset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  begin a load; sampled in IDLE and DONE only.
- abort  in  1  terminate an in-progress load.
- word_in  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  loader can accept a word this cycle.
- ccff_head  out  1  serial bit into the chain head.
- chain_clk_en  out  1  enable for the chain's clock gate; the chain samples ccff_head on this edge.
- ccff_tail  in  1  serial bit from the chain tail.
- rb_word  out  WORD_W  readback word; first-emerged bit in MSB.
- rb_valid  out  1  one-cycle strobe, no backpressure.
- busy  out  1  high in LOAD and SHIFT.
- done  out  1  sticky; CHAIN_LEN bits shifted.
- err  out  1  sticky; load was aborted.

Behaviour:
- Reset (pReset = 0, asynchronous):
  - State is IDLE.
  - word_ready, ccff_head, chain_clk_en, rb_valid, busy, done and err are 0.
  - rb_word, the shift register, the bit counter and the readback packer are 0.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE / DONE:
  - start = 1 moves to LOAD.
  - On that transition, clear done, err, the bit counter and the packer.
- LOAD:
  - word_ready = 1 and chain_clk_en = 0.
  - On word_valid & word_ready at edge t: capture word_in into the shift register and go to SHIFT.
  - The first bit appears on ccff_head, with chain_clk_en = 1, in cycle t+1.
- SHIFT:
  - Each cycle: ccff_head = shift_reg[WORD_W-1] and chain_clk_en = 1.
  - At the edge: shift left, increment the bit counter, and push ccff_tail into the packer.
  - Tail sampling uses the pre-edge value (the bit leaving the chain).
- Exit from SHIFT:
  - After the bit that makes the count equal CHAIN_LEN: go to DONE with done = 1.
  - Otherwise, after WORD_W bits of the current word: go back to LOAD.
  - No prefetch, so steady-state throughput is WORD_W bits per WORD_W+1 cycles.
  - Bubbles are harmless because chain_clk_en = 0 outside SHIFT.
- Final partial word: when CHAIN_LEN is not a multiple of WORD_W, only the top (CHAIN_LEN mod WORD_W) bits of the last word are shifted; its remaining low bits are discarded.
- Readback packer:
  - Fills MSB-first.
  - When WORD_W bits have been collected, drives rb_word and pulses rb_valid for one cycle.
  - On the final bit, a partial word is emitted with its unused low bits set to 0.
  - rb_valid fires in the cycle after the edge that pushed the last bit.
- abort:
  - Honoured in LOAD or SHIFT; has priority over shifting that cycle.
  - Goes to IDLE with err = 1 and done = 0; chain_clk_en drops immediately (combinationally from state, registered next cycle).
  - No rb_valid for a partial packer.
- Ignored inputs:
  - word_valid outside LOAD has no effect (word_ready = 0).
  - start while busy is ignored.
- busy = 1 exactly in LOAD and SHIFT.
- The bit counter never exceeds CHAIN_LEN; no wrap.

Decomposition:
- Package ccff_loader_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - default WORD_W / CHAIN_LEN constants;
  - the helper constant LAST_BITS = CHAIN_LEN % WORD_W.
- One sub-module: ccff_rb_packer.
  - Serial-to-word packer with push, flush and clear inputs.
  - Outputs rb_word and rb_valid.

Test Plan:
- Full load, default parameters:
  - Stimulus: start, then words 0xA5, 0x3C, 0xFF, 0x00, 0x9F, word_valid held high.
  - chain_clk_en is high for exactly 36 cycles.
  - ccff_head sequence is 10100101 00111100 11111111 00000000 1001; the low nibble 1111 of 0x9F is never driven.
  - done rises after the 36th bit; word_ready returns 0.
- Readback:
  - Stimulus: drive ccff_tail from a 36-bit model chain preloaded with 0xDEADBEEF5.
  - Expect 5 rb_valid pulses: 0xDE, 0xAD, 0xBE, 0xEF, 0x50.
- Starved source:
  - Stimulus: deassert word_valid for 7 cycles between words 2 and 3.
  - chain_clk_en stays 0 throughout the gap and the model chain contents are unchanged.
  - The final chain image matches the no-gap run.
- Abort mid-shift:
  - Stimulus: assert abort during bit 3 of word 2.
  - Next cycle: IDLE with err = 1, done = 0, chain_clk_en = 0, and no further rb_valid.
  - A subsequent start clears err.
- Async reset mid-SHIFT:
  - Stimulus: pull pReset low between clock edges.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the block stays in IDLE until start.
- Edge parameters:
  - CHAIN_LEN = 8, WORD_W = 8: exactly one word, one rb_valid, no discarded bits.
  - CHAIN_LEN = 1: one bit taken from word_in[7].

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam int unsigned DEF_WORD_W    = 8;
  localparam int unsigned DEF_CHAIN_LEN = 36;
  // Bits of the final word actually shifted when the chain is not word-aligned (0 = aligned).
  localparam int unsigned LAST_BITS     = DEF_CHAIN_LEN % DEF_WORD_W;

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-word packer for bits leaving the chain tail; fills MSB-first.
module ccff_rb_packer #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              clear,
  input  logic              push,
  input  logic              flush,
  input  logic              bit_in,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid
);

  localparam int unsigned FILL_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] acc_q, acc_d, acc_next;
  logic [FILL_W-1:0] fill_q, fill_d, fill_next;
  logic [WORD_W-1:0] rb_word_q, rb_word_d;
  logic              rb_valid_q, rb_valid_d;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      acc_q      <= '0;
      fill_q     <= '0;
      rb_word_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      rb_word_q  <= rb_word_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  always_comb begin
    acc_d      = acc_q;
    fill_d     = fill_q;
    rb_word_d  = rb_word_q;
    rb_valid_d = 1'b0;
    acc_next   = acc_q | (WORD_W'(bit_in) << (FILL_W'(WORD_W - 1) - fill_q));
    fill_next  = fill_q + FILL_W'(1);
    if (clear) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (push) begin
      // Unfilled low bits of a flushed partial word are still zero.
      if (flush || fill_next == FILL_W'(WORD_W)) begin
        rb_word_d  = acc_next;
        rb_valid_d = 1'b1;
        acc_d      = '0;
        fill_d     = '0;
      end else begin
        acc_d  = acc_next;
        fill_d = fill_next;
      end
    end
  end

  assign rb_word  = rb_word_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first into a config chain, gating its clock and
// packing the displaced tail bits into readback words.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned WB_W = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WB_W-1:0]   wbit_q, wbit_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              pk_push, pk_flush, pk_clear;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      wbit_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      wbit_q  <= wbit_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    wbit_d   = wbit_q;
    done_d   = done_q;
    err_d    = err_q;
    pk_push  = 1'b0;
    pk_flush = 1'b0;
    pk_clear = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StLoad;
          done_d   = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          pk_clear = 1'b1;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d  = StIdle;
          err_d    = 1'b1;
          done_d   = 1'b0;
          pk_clear = 1'b1;
        end else if (word_valid) begin
          shift_d = word_in;
          wbit_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (abort) begin
          state_d  = StIdle;
          err_d    = 1'b1;
          done_d   = 1'b0;
          pk_clear = 1'b1;
        end else begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
          wbit_d  = wbit_q + WB_W'(1);
          pk_push = 1'b1;
          // Chain end wins over word end, so a partial last word drops its low bits.
          if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
            state_d  = StDone;
            done_d   = 1'b1;
            pk_flush = 1'b1;
          end else if (wbit_q == WB_W'(WORD_W - 1)) begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    word_ready   = (state_q == StLoad);
    busy         = (state_q == StLoad) || (state_q == StShift);
    chain_clk_en = (state_q == StShift) && !abort;
    ccff_head    = (state_q == StShift) ? shift_q[WORD_W-1] : 1'b0;
    done         = done_q;
    err          = err_q;
  end

  ccff_rb_packer #(
    .WORD_W (WORD_W)
  ) u_rb_packer (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .clear    (pk_clear),
    .push     (pk_push),
    .flush    (pk_flush),
    .bit_in   (ccff_tail),
    .rb_word  (rb_word),
    .rb_valid (rb_valid)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: model chain on head/tail, scoreboard queues for head bits and
// readback words, plus small instances for the one-word and one-bit chain corners.
module tb_ccff_chain_loader;

  localparam int W = 8;
  localparam int L = 36;

  logic         prog_clk = 1'b0;
  logic         pReset   = 1'b0;
  logic         start = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_ready, ccff_head, chain_clk_en, ccff_tail, rb_valid, busy, done, err;
  logic [W-1:0] rb_word;

  int total = 0;
  int bad   = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .ccff_head(ccff_head),
    .chain_clk_en(chain_clk_en), .ccff_tail(ccff_tail), .rb_word(rb_word), .rb_valid(rb_valid),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model chain: samples ccff_head on gated edges, tail is the oldest bit.
  logic [L-1:0] chain;
  logic [L-1:0] preload_val = '0;
  logic         preload_req = 1'b0;
  assign ccff_tail = chain[L-1];
  always @(posedge prog_clk) begin
    if (preload_req)       chain <= preload_val;
    else if (chain_clk_en) chain <= {chain[L-2:0], ccff_head};
  end

  logic         head_q[$];
  logic [W-1:0] rb_q[$];
  int           en_count = 0;
  logic         in_gap = 1'b0;

  always @(posedge prog_clk) begin
    if (pReset) begin
      if (chain_clk_en) begin
        en_count++;
        if (head_q.size() == 0) chk("head_extra", chain_clk_en, 0);
        else chk("head", ccff_head, head_q.pop_front());
      end
      if (rb_valid) begin
        if (rb_q.size() == 0) chk("rb_extra", rb_valid, 0);
        else chk("rb_word", rb_word, rb_q.pop_front());
      end
      if (in_gap) chk("gap_en", chain_clk_en, 0);
    end
  end

  logic [W-1:0] words [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h9F};

  task automatic push_heads(input int n);
    for (int i = 0; i < n; i++) head_q.push_back(words[i / W][W - 1 - (i % W)]);
  endtask

  task automatic push_rb(input logic [L-1:0] pre, input int n);
    logic [W-1:0] r;
    for (int j = 0; j < n; j++) begin
      r = '0;
      for (int b = 0; b < W; b++) if (j * W + b < L) r[W-1-b] = pre[L-1-(j*W+b)];
      rb_q.push_back(r);
    end
  endtask

  task automatic preload(input logic [L-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(negedge prog_clk);
    preload_req = 1'b0;
  endtask

  task automatic begin_load();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    en_count = 0;
  endtask

  // Called and returns at a negedge; stops on done, on budget, or when stop_en bits are out.
  task automatic feed(input int gap_after, input int gap_len, input int stop_en);
    int idx = 0;
    int gcnt = 0;
    logic hs;
    logic [L-1:0] snap = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) break;
      if (stop_en > 0 && en_count == stop_en && chain_clk_en) break;
      hs = 1'b0;
      if (idx == gap_after && gcnt < gap_len && word_ready) begin
        if (gcnt == 0) snap = chain;
        word_valid = 1'b0;
        in_gap = 1'b1;
        gcnt++;
      end else begin
        if (in_gap) begin
          in_gap = 1'b0;
          chk("gap_chain", chain, snap);
        end
        if (idx < 5) begin
          word_valid = 1'b1;
          word_in = words[idx];
          hs = word_ready;
        end else word_valid = 1'b0;
      end
      @(posedge prog_clk);
      if (hs) idx++;
      @(negedge prog_clk);
    end
    word_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge prog_clk);
  endtask

  // Corner instances: one exact word, and a single-bit chain.
  logic       start8 = 1'b0, valid8 = 1'b0, start1 = 1'b0, valid1 = 1'b0, no_abort = 1'b0;
  logic [7:0] word8 = '0, word1 = '0, rbw8, rbw1, rb8_last, rb1_last;
  logic       ready8, head8, en8, rbv8, busy8, done8, err8;
  logic       ready1, head1, en1, rbv1, busy1, done1, err1;
  logic [7:0] chain8;
  logic       chain1;
  int         en8_n, rb8_n, en1_n, rb1_n;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(8)) dut8 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start8), .abort(no_abort), .word_in(word8),
    .word_valid(valid8), .word_ready(ready8), .ccff_head(head8), .chain_clk_en(en8),
    .ccff_tail(chain8[7]), .rb_word(rbw8), .rb_valid(rbv8), .busy(busy8), .done(done8),
    .err(err8)
  );

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(1)) dut1 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start1), .abort(no_abort), .word_in(word1),
    .word_valid(valid1), .word_ready(ready1), .ccff_head(head1), .chain_clk_en(en1),
    .ccff_tail(chain1), .rb_word(rbw1), .rb_valid(rbv1), .busy(busy1), .done(done1),
    .err(err1)
  );

  always @(posedge prog_clk) begin
    if (!pReset) begin
      chain8 <= 8'h6B; chain1 <= 1'b1;
      en8_n <= 0; rb8_n <= 0; en1_n <= 0; rb1_n <= 0;
    end else begin
      if (en8) begin chain8 <= {chain8[6:0], head8}; en8_n <= en8_n + 1; end
      if (rbv8) begin rb8_n <= rb8_n + 1; rb8_last <= rbw8; end
      if (en1) begin chain1 <= head1; en1_n <= en1_n + 1; end
      if (rbv1) begin rb1_n <= rb1_n + 1; rb1_last <= rbw1; end
    end
  end

  logic [L-1:0] exp_chain;

  initial begin
    #1;
    chk("rst_ready", word_ready, 0);
    chk("rst_en", chain_clk_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rbv", rb_valid, 0);
    chk("rst_rbw", rb_word, 0);
    idle(2);
    pReset = 1'b1;
    idle(2);

    // Full load with readback of a preloaded chain.
    preload(36'hDEADBEEF5);
    push_heads(L);
    push_rb(36'hDEADBEEF5, 5);
    begin_load();
    chk("load_busy", busy, 1);
    feed(99, 0, 0);
    chk("full_done", done, 1);
    chk("full_ready", word_ready, 0);
    chk("full_busy", busy, 0);
    idle(2);
    chk("full_en_cnt", en_count, L);
    chk("full_chain", chain, 36'hA53CFF009);
    chk("full_head_left", head_q.size(), 0);
    chk("full_rb_left", rb_q.size(), 0);

    // Starved source: 7-cycle gap after word 2.
    preload('0);
    push_heads(L);
    push_rb('0, 5);
    begin_load();
    feed(2, 7, 0);
    chk("gap_done", done, 1);
    idle(2);
    chk("gap_en_cnt", en_count, L);
    chk("gap_final", chain, 36'hA53CFF009);
    chk("gap_rb_left", rb_q.size(), 0);

    // Abort while the 4th bit of word 2 is on ccff_head.
    preload(36'hDEADBEEF5);
    push_heads(11);
    push_rb(36'hDEADBEEF5, 1);
    begin_load();
    feed(99, 0, 11);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_err", err, 1);
    chk("ab_done", done, 0);
    chk("ab_en", chain_clk_en, 0);
    idle(12);
    chk("ab_en_cnt", en_count, 11);
    chk("ab_rb_left", rb_q.size(), 0);
    exp_chain = 36'hDEADBEEF5;
    for (int i = 0; i < 11; i++) exp_chain = {exp_chain[L-2:0], words[i / W][W - 1 - (i % W)]};
    chk("ab_chain", chain, exp_chain);
    begin_load();
    chk("restart_err", err, 0);
    chk("restart_busy", busy, 1);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    chk("ab_load_err", err, 1);
    chk("ab_load_busy", busy, 0);

    // Async reset between edges while shifting.
    push_heads(L);
    begin_load();
    feed(99, 0, 3);
    #2 pReset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_en", chain_clk_en, 0);
    chk("arst_head", ccff_head, 0);
    chk("arst_ready", word_ready, 0);
    chk("arst_rbw", rb_word, 0);
    chk("arst_err", err, 0);
    head_q.delete();
    @(negedge prog_clk);
    pReset = 1'b1;
    word_valid = 1'b1;
    idle(5);
    word_valid = 1'b0;
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_ready", word_ready, 0);
    chk("arst_idle_done", done, 0);

    // One-word chain.
    start8 = 1'b1;
    @(negedge prog_clk);
    start8 = 1'b0;
    chk("e8_ready", ready8, 1);
    valid8 = 1'b1;
    word8 = 8'hC3;
    @(negedge prog_clk);
    valid8 = 1'b0;
    for (int i = 0; i < 40 && !done8; i++) @(negedge prog_clk);
    idle(2);
    chk("e8_done", done8, 1);
    chk("e8_en_cnt", en8_n, 8);
    chk("e8_rb_cnt", rb8_n, 1);
    chk("e8_rb_word", rb8_last, 8'h6B);
    chk("e8_chain", chain8, 8'hC3);

    // Single-bit chain takes word_in[7] only.
    start1 = 1'b1;
    @(negedge prog_clk);
    start1 = 1'b0;
    valid1 = 1'b1;
    word1 = 8'h7F;
    @(negedge prog_clk);
    valid1 = 1'b0;
    for (int i = 0; i < 40 && !done1; i++) @(negedge prog_clk);
    idle(2);
    chk("e1_done", done1, 1);
    chk("e1_en_cnt", en1_n, 1);
    chk("e1_rb_cnt", rb1_n, 1);
    chk("e1_rb_word", rb1_last, 8'h80);
    chk("e1_chain", chain1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
